l2_sio_resp_tracker: RTL

Synthesizable, parametrised successor to the per-bank L2-to-SIO outbound response printers. Captures every L2 bank response packet on the L2B→SIO interface: header, payload beat count, parity and UE status. Emits one record per packet over a single valid/ready event stream for scoreboards or hardware trace. Sits beside the SIO on iol2clk and taps the l2bN_sio_* nets.

---
 rtl/l2sio_mon_pkg.sv | 30 +++
 rtl/l2sio_bank_capture.sv | 117 +++++++++++
 rtl/l2_sio_resp_tracker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/l2sio_mon_pkg.sv
// Shared types for the L2-to-SIO response tracker: header field offsets,
// event record layout and the per-bank capture FSM states.
package l2sio_mon_pkg;

  localparam int OPES_MSB = 23;
  localparam int CBA_MSB  = 19;
  localparam int TAG_MSB  = 15;

  // Record fields are sized for the largest supported configuration
  // (up to 256 banks, up to 255 beats); the top trims them to port widths.
  localparam int EVT_BANK_W  = 8;
  localparam int EVT_BEATS_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [EVT_BANK_W-1:0]  bank;
    logic [3:0]             opes;
    logic [3:0]             cba;
    logic [15:0]            tag;
    logic [EVT_BEATS_W-1:0] beats;
    logic                   ue;
    logic                   par_err;
    logic                   proto_err;
  } l2sio_evt_t;

endpackage

// File: rtl/l2sio_bank_capture.sv
// One L2 bank tap: header/payload FSM, beat counter, parity check and a
// one-entry hold register feeding the top-level arbiter.
module l2sio_bank_capture
  import l2sio_mon_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PAR_W       = 2,
  parameter int RD_BEATS    = 16,
  parameter int RD_OPES_BIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              ctag_vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PAR_W-1:0]  parity_i,
  input  logic              ue_err_i,
  input  logic              pop_i,
  output logic              hold_vld_o,
  output l2sio_evt_t        hold_rec_o,
  output logic [1:0]        drop_num_o
);

  localparam int SLICE_W = DATA_W / PAR_W;

  cap_state_e       state_q, state_d;
  l2sio_evt_t       rec_q, rec_d, hdr_rec, beat_rec, done_rec, hold_q;
  logic [PAR_W-1:0] slice_err;
  logic             done, extra_done, accept, hold_vld_q;

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    assign slice_err[gi] = (^data_i[gi*SLICE_W +: SLICE_W]) ^ parity_i[gi];
  end

  always_comb begin
    hdr_rec          = '0;
    hdr_rec.opes     = data_i[OPES_MSB -: 4];
    hdr_rec.cba      = data_i[CBA_MSB -: 4];
    hdr_rec.tag      = data_i[TAG_MSB -: 16];
    hdr_rec.ue       = ue_err_i;
    beat_rec         = rec_q;
    beat_rec.beats   = rec_q.beats + EVT_BEATS_W'(1);
    beat_rec.ue      = rec_q.ue | ue_err_i;
    beat_rec.par_err = rec_q.par_err | (|slice_err);
  end

  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    done       = 1'b0;
    done_rec   = rec_q;
    extra_done = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctag_vld_i) begin
            rec_d = hdr_rec;
            if (hdr_rec.opes[RD_OPES_BIT]) begin
              state_d = PAYLOAD;
            end else begin
              done     = 1'b1;
              done_rec = hdr_rec;
            end
          end
        end
        PAYLOAD: begin
          if (ctag_vld_i) begin
            done               = 1'b1;
            done_rec.proto_err = 1'b1;
            rec_d              = hdr_rec;
            // A header-only packet truncating a read yields a second record
            // this cycle; the hold register takes one, so the second is lost.
            if (!hdr_rec.opes[RD_OPES_BIT]) begin
              state_d    = IDLE;
              extra_done = 1'b1;
            end
          end else begin
            rec_d = beat_rec;
            if (beat_rec.beats == EVT_BEATS_W'(RD_BEATS)) begin
              done     = 1'b1;
              done_rec = beat_rec;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign accept = ~hold_vld_q | pop_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      rec_q      <= '0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      if (done && accept) begin
        hold_vld_q <= 1'b1;
        hold_q     <= done_rec;
      end else if (pop_i) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

  assign hold_vld_o = hold_vld_q;
  assign hold_rec_o = hold_q;
  assign drop_num_o = {1'b0, done & ~accept} + {1'b0, extra_done};

endmodule

// File: rtl/l2_sio_resp_tracker.sv
// L2B->SIO response tracker: per-bank capture, round-robin arbitration of
// completed records into an event FIFO, and drop accounting.
module l2_sio_resp_tracker
  import l2sio_mon_pkg::*;
#(
  parameter int NUM_BANKS   = 8,
  parameter int DATA_W      = 32,
  parameter int PAR_W       = 2,
  parameter int RD_BEATS    = 16,
  parameter int RD_OPES_BIT = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            iol2clk,
  input  logic                            rst_l,
  input  logic                            enable,
  input  logic [NUM_BANKS-1:0]            bank_ctag_vld,
  input  logic [NUM_BANKS*DATA_W-1:0]     bank_data,
  input  logic [NUM_BANKS*PAR_W-1:0]      bank_parity,
  input  logic [NUM_BANKS-1:0]            bank_ue_err,
  output logic                            evt_vld,
  input  logic                            evt_rdy,
  output logic [$clog2(NUM_BANKS)-1:0]    evt_bank,
  output logic [3:0]                      evt_opes,
  output logic [3:0]                      evt_cba,
  output logic [15:0]                     evt_tag,
  output logic [$clog2(RD_BEATS+1)-1:0]   evt_beats,
  output logic                            evt_ue,
  output logic                            evt_par_err,
  output logic                            evt_proto_err,
  output logic [15:0]                     drop_cnt,
  output logic                            ovf_sticky
);

  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int BEATS_W = $clog2(RD_BEATS + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  logic [NUM_BANKS-1:0] hold_vld, pop_vec;
  l2sio_evt_t           hold_rec [NUM_BANKS];
  logic [1:0]           drop_num [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    l2sio_bank_capture #(
      .DATA_W(DATA_W), .PAR_W(PAR_W), .RD_BEATS(RD_BEATS), .RD_OPES_BIT(RD_OPES_BIT)
    ) u_cap (
      .clk_i      (iol2clk),
      .rst_n_i    (rst_l),
      .enable_i   (enable),
      .ctag_vld_i (bank_ctag_vld[gi]),
      .data_i     (bank_data[gi*DATA_W +: DATA_W]),
      .parity_i   (bank_parity[gi*PAR_W +: PAR_W]),
      .ue_err_i   (bank_ue_err[gi]),
      .pop_i      (pop_vec[gi]),
      .hold_vld_o (hold_vld[gi]),
      .hold_rec_o (hold_rec[gi]),
      .drop_num_o (drop_num[gi])
    );
  end

  logic [BANK_W-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
  logic              grant_vld, push, pop, full;
  l2sio_evt_t        push_rec, head;
  l2sio_evt_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic [16:0]       drop_sum, drop_total;
  logic [15:0]       drop_cnt_q;
  logic              ovf_q;

  assign full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop  = evt_vld & evt_rdy;

  // Search starts at the pointer so the bank granted last gets lowest priority.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_BANKS) idx = idx - NUM_BANKS;
      if (!grant_vld && hold_vld[idx]) begin
        grant_vld = 1'b1;
        grant_idx = BANK_W'(idx);
      end
    end
    push          = grant_vld & (~full | pop);
    pop_vec       = '0;
    push_rec      = hold_rec[grant_idx];
    push_rec.bank = EVT_BANK_W'(grant_idx);
    rr_ptr_d      = rr_ptr_q;
    if (push) begin
      pop_vec[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == BANK_W'(NUM_BANKS - 1)) ? '0 : grant_idx + BANK_W'(1);
    end
  end

  always_comb begin
    drop_sum = '0;
    for (int b = 0; b < NUM_BANKS; b++) drop_sum = drop_sum + 17'(drop_num[b]);
    drop_total = {1'b0, drop_cnt_q} + drop_sum;
  end

  always_ff @(posedge iol2clk) begin
    if (push) mem_q[wr_ptr_q] <= push_rec;
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      drop_cnt_q <= drop_total[16] ? 16'hFFFF : drop_total[15:0];
      if (drop_sum != '0) ovf_q <= 1'b1;
    end
  end

  assign evt_vld       = (cnt_q != '0);
  assign head          = evt_vld ? mem_q[rd_ptr_q] : '0;
  assign evt_bank      = head.bank[BANK_W-1:0];
  assign evt_opes      = head.opes;
  assign evt_cba       = head.cba;
  assign evt_tag       = head.tag;
  assign evt_beats     = head.beats[BEATS_W-1:0];
  assign evt_ue        = head.ue;
  assign evt_par_err   = head.par_err;
  assign evt_proto_err = head.proto_err;
  assign drop_cnt      = drop_cnt_q;
  assign ovf_sticky    = ovf_q;

  logic unused_bits;
  assign unused_bits = ^{head.bank[EVT_BANK_W-1:BANK_W], head.beats[EVT_BEATS_W-1:BEATS_W]};

endmodule
